// File: rtl/lane_serializer.sv
// Word-to-lane serializer: words queue in a small FIFO and leave MS lane first over a
// valid/ready lane port, framed by sof/eof with an optional trailing XOR checksum lane.
module lane_serializer #(
  parameter int WORD_W     = 24,
  parameter int LANE_W     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CHECKSUM   = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [WORD_W-1:0]             in_word,
  input  logic                          write,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [LANE_W-1:0]             lane_out,
  output logic                          lane_valid,
  input  logic                          lane_ready,
  output logic                          sof,
  output logic                          eof
);
  localparam int NLANES = WORD_W / LANE_W;
  localparam int IDX_W  = $clog2(NLANES);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NLANES - 1);
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SHIFT, CSUM} state_t;

  state_t                state, state_n;
  logic [WORD_W-1:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [PTR_W:0]        count_n;
  logic [WORD_W-1:0]     shifter, shifter_n;
  logic [IDX_W-1:0]      lane_idx, idx_n;
  logic [LANE_W-1:0]     csum, csum_n, lane_n;
  logic                  valid_n, sof_n, eof_n;
  logic                  push, pop, transfer, end_word;

  // Handshake: a lane moves when lane_valid & lane_ready are both high at a rising edge;
  // while valid is high and ready low, lane_out/sof/eof hold. A write is taken only when
  // the registered full flag is low, independent of any pop on the same edge.
  assign transfer = lane_valid & lane_ready;
  assign push     = write & ~full;

  always_comb begin
    state_n   = state;
    shifter_n = shifter;
    idx_n     = lane_idx;
    csum_n    = csum;
    pop       = 1'b0;
    end_word  = 1'b0;
    case (state)
      SHIFT: begin
        if (transfer) begin
          csum_n = csum ^ lane_out;
          if (lane_idx == LAST_IDX) begin
            if (CHECKSUM != 0) state_n = CSUM;
            else               end_word = 1'b1;
          end else begin
            idx_n = lane_idx + 1'b1;
          end
        end
      end
      CSUM:    if (transfer) end_word = 1'b1;
      default: state_n = IDLE;
    endcase
    if (end_word) begin
      state_n = IDLE;
      idx_n   = '0;
    end
    // Loading at end of word as well as from IDLE gives back-to-back words with no bubble.
    if ((state == IDLE || end_word) && fifo_count != '0) begin
      pop       = 1'b1;
      shifter_n = mem[rd_ptr];
      idx_n     = '0;
      csum_n    = '0;
      state_n   = SHIFT;
    end
  end

  // Registered outputs are precomputed from the next-state values.
  always_comb begin
    valid_n = (state_n != IDLE);
    sof_n   = (state_n == SHIFT) && (idx_n == '0);
    eof_n   = (state_n == CSUM) ||
              ((state_n == SHIFT) && (idx_n == LAST_IDX) && (CHECKSUM == 0));
    lane_n  = '0;
    if (state_n == CSUM)
      lane_n = csum_n;
    else if (state_n == SHIFT)
      lane_n = LANE_W'(shifter_n >> (LANE_W * (NLANES - 1 - int'(idx_n))));
  end

  always_comb begin
    count_n = fifo_count;
    case ({push, pop})
      2'b10:   count_n = fifo_count + 1'b1;
      2'b01:   count_n = fifo_count - 1'b1;
      default: count_n = fifo_count;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shifter    <= '0;
      lane_idx   <= '0;
      csum       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      full       <= 1'b0;
      overflow   <= 1'b0;
      lane_out   <= '0;
      lane_valid <= 1'b0;
      sof        <= 1'b0;
      eof        <= 1'b0;
    end else begin
      state      <= state_n;
      shifter    <= shifter_n;
      lane_idx   <= idx_n;
      csum       <= csum_n;
      fifo_count <= count_n;
      full       <= (count_n == DEPTH_CNT);
      lane_out   <= lane_n;
      lane_valid <= valid_n;
      sof        <= sof_n;
      eof        <= eof_n;
      if (push)          wr_ptr   <= wr_ptr + 1'b1;
      if (pop)           rd_ptr   <= rd_ptr + 1'b1;
      if (write && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_word;
  end
endmodule

// File: tb/tb_lane_serializer.sv
// Bench for lane_serializer: checksum and no-checksum instances share stimulus; a lane-level
// reference model feeds per-instance expected queues drained by negedge monitors.
module tb_lane_serializer;
  localparam int WORD_W = 24, LANE_W = 4, FIFO_DEPTH = 4;
  localparam int NL = WORD_W / LANE_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = LANE_W + 2;

  logic clk = 1'b0, reset = 1'b1, write = 1'b0, lane_ready = 1'b0;
  logic [WORD_W-1:0] in_word = '0;
  logic full_c, ovf_c, valid_c, sof_c, eof_c, full_n, ovf_n, valid_n, sof_n, eof_n;
  logic [CNT_W-1:0] cnt_c, cnt_n;
  logic [LANE_W-1:0] lane_c, lane_n;

  logic [EW-1:0] exp_c[$], exp_n[$];
  logic [EW-1:0] e_c, e_n;
  int checks = 0, failures = 0;
  int written = 0, done_c = 0, done_n = 0;

  lane_serializer #(.WORD_W(WORD_W), .LANE_W(LANE_W), .FIFO_DEPTH(FIFO_DEPTH), .CHECKSUM(1)) u_cs (
    .clk(clk), .reset(reset), .in_word(in_word), .write(write), .full(full_c),
    .fifo_count(cnt_c), .overflow(ovf_c), .lane_out(lane_c), .lane_valid(valid_c),
    .lane_ready(lane_ready), .sof(sof_c), .eof(eof_c));

  lane_serializer #(.WORD_W(WORD_W), .LANE_W(LANE_W), .FIFO_DEPTH(FIFO_DEPTH), .CHECKSUM(0)) u_nc (
    .clk(clk), .reset(reset), .in_word(in_word), .write(write), .full(full_n),
    .fifo_count(cnt_n), .overflow(ovf_n), .lane_out(lane_n), .lane_valid(valid_n),
    .lane_ready(lane_ready), .sof(sof_n), .eof(eof_n));

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [LANE_W-1:0] lane_of(input logic [WORD_W-1:0] w, input int i);
    return LANE_W'(w >> (LANE_W * (NL - 1 - i)));
  endfunction

  // reference model: a word becomes NL lanes MS first, plus an XOR lane when checksummed
  task automatic model_push(input logic [WORD_W-1:0] w);
    logic [LANE_W-1:0] l, cs;
    cs = '0;
    for (int i = 0; i < NL; i++) begin
      l = lane_of(w, i);
      cs ^= l;
      exp_c.push_back({i == 0, 1'b0, l});
      exp_n.push_back({i == 0, i == NL - 1, l});
    end
    exp_c.push_back({1'b0, 1'b1, cs});
    written++;
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [WORD_W-1:0] w, input bit accept);
    in_word = w;
    write = 1'b1;
    if (accept) model_push(w);
    tick();
    write = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    bit busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
      busy = (exp_c.size() != 0) || (exp_n.size() != 0) || valid_c || valid_n;
    end
    checks++;
    if (busy) begin
      failures++;
      $display("FAIL %s_drain: got %0d/%0d lanes pending after %0d cycles expected 0",
               name, exp_c.size(), exp_n.size(), n);
    end
    tick();
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_lane_c"}, 32'(lane_c), 32'd0);
    check({name, "_valid_c"}, 32'(valid_c), 32'd0);
    check({name, "_sofeof_c"}, 32'({sof_c, eof_c}), 32'd0);
    check({name, "_full_c"}, 32'(full_c), 32'd0);
    check({name, "_cnt_c"}, 32'(cnt_c), 32'd0);
    check({name, "_ovf_c"}, 32'(ovf_c), 32'd0);
    check({name, "_lane_n"}, 32'(lane_n), 32'd0);
    check({name, "_valid_n"}, 32'(valid_n), 32'd0);
    check({name, "_sofeof_n"}, 32'({sof_n, eof_n}), 32'd0);
    check({name, "_ovf_n"}, 32'(ovf_n), 32'd0);
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    if (!reset && valid_c && lane_ready) begin
      if (exp_c.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL cs_lane: got extra lane %0h expected none", lane_c);
      end else begin
        e_c = exp_c.pop_front();
        check("cs_lane", 32'({sof_c, eof_c, lane_c}), 32'(e_c));
      end
      if (eof_c) done_c++;
    end
  end

  always @(negedge clk) begin
    if (!reset && valid_n && lane_ready) begin
      if (exp_n.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL nc_lane: got extra lane %0h expected none", lane_n);
      end else begin
        e_n = exp_n.pop_front();
        check("nc_lane", 32'({sof_n, eof_n, lane_n}), 32'(e_n));
      end
      if (eof_n) done_n++;
    end
  end

  initial begin
    logic [WORD_W-1:0] w;
    // reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    tick();
    reset = 1'b0;
    lane_ready = 1'b1;

    // single word, continuous ready: 7 / 6 contiguous lanes
    write_word(24'hB98EA1, 1'b1);
    @(negedge clk);
    check("t1_gap_c", 32'(valid_c), 32'd0);
    for (int i = 0; i < NL + 1; i++) begin
      @(negedge clk);
      check("t1_valid_c", 32'(valid_c), 32'd1);
      check("t1_valid_n", 32'(valid_n), 32'(i < NL));
    end
    @(negedge clk);
    check("t1_end_valid_c", 32'(valid_c), 32'd0);
    check("t1_end_cnt_c", 32'(cnt_c), 32'd0);
    check("t1_end_cnt_n", 32'(cnt_n), 32'd0);
    tick();

    // stall after third transfer
    w = 24'hB98EA1;
    write_word(w, 1'b1);
    repeat (4) tick();
    lane_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_hold_c", 32'({valid_c, sof_c, eof_c, lane_c}), 32'({3'b100, lane_of(w, 3)}));
      check("t2_hold_n", 32'({valid_n, sof_n, eof_n, lane_n}), 32'({3'b100, lane_of(w, 3)}));
    end
    tick();
    lane_ready = 1'b1;
    wait_drain("t2", 50);

    // back-to-back words, no bubble
    write_word(24'hB98EA1, 1'b1);
    write_word(24'h000000, 1'b1);
    for (int i = 0; i < 2 * (NL + 1); i++) begin
      @(negedge clk);
      check("t3_valid_c", 32'(valid_c), 32'd1);
      check("t3_valid_n", 32'(valid_n), 32'(i < 2 * NL));
    end
    @(negedge clk);
    check("t3_end_c", 32'(valid_c), 32'd0);
    tick();

    // random traffic, writes only when the model knows there is room
    for (int c = 0; c < 600; c++) begin
      lane_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0 && (written - done_c) < FIFO_DEPTH &&
          (written - done_n) < FIFO_DEPTH)
        write_word($urandom(), 1'b1);
      else
        tick();
    end
    lane_ready = 1'b1;
    wait_drain("rand", 200);
    check("rand_ovf_c", 32'(ovf_c), 32'd0);
    check("rand_ovf_n", 32'(ovf_n), 32'd0);

    // overflow: 6 writes with sink stalled, FIFO_DEPTH+1 survive
    lane_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_word = $urandom();
      write = 1'b1;
      if (i < FIFO_DEPTH + 1) model_push(in_word);
      if (i == 5) begin
        @(negedge clk);
        check("t4_full_c", 32'(full_c), 32'd1);
        check("t4_cnt_c", 32'(cnt_c), 32'(FIFO_DEPTH));
        check("t4_cnt_n", 32'(cnt_n), 32'(FIFO_DEPTH));
        check("t4_pre_ovf_c", 32'(ovf_c), 32'd0);
      end
      tick();
    end
    write = 1'b0;
    @(negedge clk);
    check("t4_ovf_c", 32'(ovf_c), 32'd1);
    check("t4_ovf_n", 32'(ovf_n), 32'd1);
    check("t4_full_n", 32'(full_n), 32'd1);
    tick();
    lane_ready = 1'b1;
    wait_drain("t4", 100);
    check("t4_sticky_c", 32'(ovf_c), 32'd1);

    // reset mid-word after two lanes
    write_word($urandom(), 1'b1);
    repeat (3) tick();
    reset = 1'b1;
    exp_c.delete();
    exp_n.delete();
    written = 0;
    done_c = 0;
    done_n = 0;
    @(negedge clk);
    check_reset_outputs("t5");
    tick();
    reset = 1'b0;
    write_word(24'h123456, 1'b1);
    wait_drain("t5", 50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
